// File: rtl/addr_xlate.sv
// Address translation stage: unmapped segments bypass the TLB; mapped segments use the
// external combinational TLB search port. The result sits in one ready/valid output register.
module addr_xlate #(
  parameter int TLBNUM = 16,
  localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_vaddr,
  input  logic          req_wr,
  input  logic [7:0]    cur_asid,

  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  input  logic [19:0]   s_pfn,
  input  logic [2:0]    s_c,
  input  logic          s_d,
  input  logic          s_v,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_vaddr,
  output logic [31:0]   rsp_paddr,
  output logic          rsp_cached,
  output logic          rsp_ex,
  output logic          rsp_refill,
  output logic [4:0]    rsp_excode,
  output logic [IW-1:0] rsp_index,

  output logic [15:0]   miss_cnt
);

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  logic          r_rsp_valid;
  logic [31:0]   r_rsp_vaddr;
  logic [31:0]   r_rsp_paddr;
  logic          r_rsp_cached;
  logic          r_rsp_ex;
  logic          r_rsp_refill;
  logic [4:0]    r_rsp_excode;
  logic [IW-1:0] r_rsp_index;
  logic [15:0]   r_miss_cnt;

  logic          w_accept;
  logic          w_unmapped;
  logic [31:0]   w_paddr;
  logic          w_cached;
  logic          w_ex;
  logic          w_refill;
  logic [4:0]    w_excode;
  logic [IW-1:0] w_index;
  logic          w_miss;
  logic [4:0]    w_tlb_excode;

  assign s_vpn2     = req_vaddr[31:13];
  assign s_odd_page = req_vaddr[12];
  assign s_asid     = cur_asid;

  // Ready depends only on the output register, never on req_valid.
  assign req_ready  = reset || !r_rsp_valid || rsp_ready;
  assign w_accept   = req_valid && req_ready && !reset;

  assign w_unmapped   = (req_vaddr[31:30] == 2'b10);
  assign w_tlb_excode = req_wr ? EXC_TLBS : EXC_TLBL;

  always_comb begin
    w_paddr  = 32'd0;
    w_cached = 1'b0;
    w_ex     = 1'b0;
    w_refill = 1'b0;
    w_excode = 5'd0;
    w_index  = '0;
    w_miss   = 1'b0;
    if (w_unmapped) begin
      w_paddr  = {3'b000, req_vaddr[28:0]};
      w_cached = !req_vaddr[29];
    end else if (!s_found) begin
      w_ex     = 1'b1;
      w_refill = 1'b1;
      w_excode = w_tlb_excode;
      w_index  = s_index;
      w_miss   = 1'b1;
    end else if (!s_v) begin
      w_ex     = 1'b1;
      w_excode = w_tlb_excode;
      w_index  = s_index;
    end else if (req_wr && !s_d) begin
      w_ex     = 1'b1;
      w_excode = EXC_MOD;
      w_index  = s_index;
    end else begin
      w_paddr  = {s_pfn, req_vaddr[11:0]};
      w_cached = (s_c == 3'd3);
      w_index  = s_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_vaddr  <= 32'd0;
      r_rsp_paddr  <= 32'd0;
      r_rsp_cached <= 1'b0;
      r_rsp_ex     <= 1'b0;
      r_rsp_refill <= 1'b0;
      r_rsp_excode <= 5'd0;
      r_rsp_index  <= '0;
      r_miss_cnt   <= 16'd0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_vaddr  <= req_vaddr;
      r_rsp_paddr  <= w_paddr;
      r_rsp_cached <= w_cached;
      r_rsp_ex     <= w_ex;
      r_rsp_refill <= w_refill;
      r_rsp_excode <= w_excode;
      r_rsp_index  <= w_index;
      if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_vaddr  = r_rsp_vaddr;
  assign rsp_paddr  = r_rsp_paddr;
  assign rsp_cached = r_rsp_cached;
  assign rsp_ex     = r_rsp_ex;
  assign rsp_refill = r_rsp_refill;
  assign rsp_excode = r_rsp_excode;
  assign rsp_index  = r_rsp_index;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_addr_xlate.sv
// Bench for addr_xlate: emulates a 16-entry TLB and checks responses against a
// transaction-level translation model.
module tb_addr_xlate;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlbe_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] paddr;
    logic        cached;
    logic        ex;
    logic        refill;
    logic [4:0]  excode;
    logic [3:0]  index;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_vaddr;
  logic [7:0]  cur_asid;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic [7:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [3:0]  s_index;
  logic [19:0] s_pfn;
  logic [2:0]  s_c;
  logic        rsp_valid, rsp_ready, rsp_cached, rsp_ex, rsp_refill;
  logic [31:0] rsp_vaddr, rsp_paddr;
  logic [4:0]  rsp_excode;
  logic [3:0]  rsp_index;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad = 0;

  addr_xlate #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_wr(req_wr), .cur_asid(cur_asid),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c),
    .s_d(s_d), .s_v(s_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vaddr(rsp_vaddr),
    .rsp_paddr(rsp_paddr), .rsp_cached(rsp_cached), .rsp_ex(rsp_ex),
    .rsp_refill(rsp_refill), .rsp_excode(rsp_excode), .rsp_index(rsp_index),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // TLB storage with a single write port; writes land at the clock edge.
  tlbe_t       tlb [16];
  logic        w_en = 1'b0;
  logic [3:0]  w_idx = 4'd0;
  tlbe_t       w_entry = '0;

  always @(posedge clk) if (w_en) tlb[w_idx] <= w_entry;

  logic       srch_f;
  logic [3:0] srch_i;
  always_comb begin
    srch_f = 1'b0;
    srch_i = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!srch_f && tlb[i].vpn2 == s_vpn2 && (tlb[i].g || tlb[i].asid == s_asid)) begin
        srch_f = 1'b1;
        srch_i = i[3:0];
      end
    end
    s_found = srch_f;
    s_index = srch_i;
    s_pfn   = s_odd_page ? tlb[srch_i].pfn1 : tlb[srch_i].pfn0;
    s_c     = s_odd_page ? tlb[srch_i].c1   : tlb[srch_i].c0;
    s_d     = s_odd_page ? tlb[srch_i].d1   : tlb[srch_i].d0;
    s_v     = s_odd_page ? tlb[srch_i].v1   : tlb[srch_i].v0;
  end

  // Reference translation following the MIPS-style segment and TLB rules.
  function automatic rsp_t xlate(logic [31:0] va, logic wr, logic [7:0] asid);
    rsp_t   r;
    logic   found;
    int     idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d, v;
    r = '0;
    r.vaddr = va;
    if (va[31:30] == 2'b10) begin
      r.paddr  = va & 32'h1FFF_FFFF;
      r.cached = (va[29] == 1'b0);
      return r;
    end
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (!found && tlb[i].vpn2 == va[31:13] && (tlb[i].g || tlb[i].asid == asid)) begin
        found = 1'b1;
        idx = i;
      end
    end
    pfn = va[12] ? tlb[idx].pfn1 : tlb[idx].pfn0;
    c   = va[12] ? tlb[idx].c1   : tlb[idx].c0;
    d   = va[12] ? tlb[idx].d1   : tlb[idx].d0;
    v   = va[12] ? tlb[idx].v1   : tlb[idx].v0;
    r.index = idx[3:0];
    if (!found) begin
      r.ex = 1'b1; r.refill = 1'b1; r.excode = wr ? 5'd3 : 5'd2;
    end else if (!v) begin
      r.ex = 1'b1; r.excode = wr ? 5'd3 : 5'd2;
    end else if (wr && !d) begin
      r.ex = 1'b1; r.excode = 5'd1;
    end else begin
      r.paddr  = {pfn, va[11:0]};
      r.cached = (c == 3'd3);
    end
    return r;
  endfunction

  logic        m_valid;
  rsp_t        m_rsp;
  logic [15:0] m_miss;
  rsp_t        m_next;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_rsp   <= '0;
      m_miss  <= 16'd0;
    end else if (req_valid && (!m_valid || rsp_ready)) begin
      m_next = xlate(req_vaddr, req_wr, cur_asid);
      m_valid <= 1'b1;
      m_rsp   <= m_next;
      if (m_next.refill) m_miss <= (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  logic [93:0] obs_all, exp_all;
  assign obs_all = {rsp_valid, rsp_vaddr, rsp_paddr, rsp_cached, rsp_ex, rsp_refill,
                    rsp_excode, rsp_index, miss_cnt, req_ready};
  assign exp_all = {m_valid, m_rsp, m_miss, (reset || !m_valid || rsp_ready)};

  function automatic tlbe_t mk(logic [18:0] vpn2, logic [7:0] asid, logic g,
                               logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                               logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
    tlbe_t e;
    e = {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    return e;
  endfunction

  function automatic tlbe_t rand_entry(int idx);
    tlbe_t e;
    e = tlbe_t'({$urandom, $urandom, $urandom});
    e.vpn2 = 19'h10000 + 19'(idx);
    e.g    = ($urandom_range(0, 3) == 0);
    return e;
  endfunction

  task automatic tlb_write(input int idx, input tlbe_t e);
    @(negedge clk);
    w_en = 1'b1; w_idx = idx[3:0]; w_entry = e;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] va, input logic wr, input logic [7:0] asid);
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = va; req_wr = wr; cur_asid = asid;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_vaddr = 32'h9FC0_1234;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++;
    if ({rsp_valid, rsp_vaddr, rsp_paddr, rsp_cached, rsp_ex, rsp_refill, rsp_excode, rsp_index, miss_cnt} !== 93'd0) begin
      bad++; $display("FAIL reset_state got valid=%b paddr=%h miss=%h want all zero", rsp_valid, rsp_paddr, miss_cnt);
    end
    reset = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_unmapped;
    send(32'h9FC0_1234, 1'b0, 8'h00);
    total++;
    if ({rsp_valid, rsp_paddr, rsp_cached, rsp_ex, rsp_index} !== {1'b1, 32'h1FC0_1234, 1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL kseg0 got v=%b pa=%h c=%b ex=%b want v=1 pa=1fc01234 c=1 ex=0", rsp_valid, rsp_paddr, rsp_cached, rsp_ex);
    end
    send(32'hBFC0_0000, 1'b1, 8'h00);
    total++;
    if ({rsp_paddr, rsp_cached, rsp_ex, rsp_vaddr} !== {32'h1FC0_0000, 1'b0, 1'b0, 32'hBFC0_0000}) begin
      bad++; $display("FAIL kseg1 got pa=%h c=%b ex=%b va=%h want pa=1fc00000 c=0 ex=0", rsp_paddr, rsp_cached, rsp_ex, rsp_vaddr);
    end
  endtask

  task automatic test_tlb_hit;
    tlb_write(5, mk(19'h00400, 8'h12, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0ABCD, 3'd3, 1'b0, 1'b1));
    send(32'h0080_1ABC, 1'b0, 8'h12);
    total++;
    if ({rsp_paddr, rsp_cached, rsp_ex, rsp_index, miss_cnt} !== {32'h0ABC_DABC, 1'b1, 1'b0, 4'd5, 16'd0}) begin
      bad++; $display("FAIL tlb_hit got pa=%h c=%b ex=%b idx=%0d miss=%0d want pa=0abcdabc c=1 ex=0 idx=5 miss=0",
                      rsp_paddr, rsp_cached, rsp_ex, rsp_index, miss_cnt);
    end
  endtask

  task automatic test_exceptions;
    tlb_write(6, mk(19'h00500, 8'h12, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b1, 20'h22222, 3'd3, 1'b1, 1'b0));
    send(32'h00A0_0010, 1'b1, 8'h12);
    total++;
    if ({rsp_ex, rsp_refill, rsp_excode, rsp_paddr, rsp_cached, rsp_index} !== {1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 4'd6}) begin
      bad++; $display("FAIL mod_exc got ex=%b rf=%b code=%0d pa=%h idx=%0d want ex=1 rf=0 code=1 pa=0 idx=6",
                      rsp_ex, rsp_refill, rsp_excode, rsp_paddr, rsp_index);
    end
    send(32'h00A0_1010, 1'b0, 8'h12);
    total++;
    if ({rsp_ex, rsp_refill, rsp_excode, rsp_index} !== {1'b1, 1'b0, 5'd2, 4'd6}) begin
      bad++; $display("FAIL inv_load got ex=%b rf=%b code=%0d idx=%0d want ex=1 rf=0 code=2 idx=6", rsp_ex, rsp_refill, rsp_excode, rsp_index);
    end
    send(32'h00A0_1010, 1'b1, 8'h12);
    total++;
    if ({rsp_ex, rsp_refill, rsp_excode} !== {1'b1, 1'b0, 5'd3}) begin
      bad++; $display("FAIL inv_store got ex=%b rf=%b code=%0d want ex=1 rf=0 code=3", rsp_ex, rsp_refill, rsp_excode);
    end
    send(32'h00A0_0010, 1'b0, 8'h12);
    total++;
    if ({rsp_ex, rsp_refill, rsp_excode, rsp_paddr, rsp_cached} !== {1'b0, 1'b0, 5'd0, 32'h1111_1010, 1'b0}) begin
      bad++; $display("FAIL uncached_hit got ex=%b code=%0d pa=%h c=%b want ex=0 code=0 pa=11111010 c=0", rsp_ex, rsp_excode, rsp_paddr, rsp_cached);
    end
  endtask

  task automatic test_miss;
    send(32'h7FFF_0000, 1'b0, 8'h12);
    total++;
    if ({rsp_ex, rsp_refill, rsp_excode, rsp_paddr, miss_cnt} !== {1'b1, 1'b1, 5'd2, 32'd0, 16'd1}) begin
      bad++; $display("FAIL miss_load got ex=%b rf=%b code=%0d pa=%h miss=%0d want ex=1 rf=1 code=2 pa=0 miss=1",
                      rsp_ex, rsp_refill, rsp_excode, rsp_paddr, miss_cnt);
    end
    send(32'h00C0_0000, 1'b1, 8'h12);
    total++;
    if ({rsp_refill, rsp_excode, miss_cnt} !== {1'b1, 5'd3, 16'd2}) begin
      bad++; $display("FAIL miss_store got rf=%b code=%0d miss=%0d want rf=1 code=3 miss=2", rsp_refill, rsp_excode, miss_cnt);
    end
  endtask

  task automatic test_asid_tlbwrite;
    tlb_write(7, mk(19'h00700, 8'h12, 1'b0, 20'h33333, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    // Request and TLB rewrite of the same entry on the same edge.
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = 32'h00E0_0044; req_wr = 1'b0; cur_asid = 8'h12;
    w_en = 1'b1; w_idx = 4'd7;
    w_entry = mk(19'h00700, 8'h12, 1'b0, 20'h44444, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    w_en = 1'b0;
    total++;
    if (rsp_paddr !== 32'h3333_3044) begin bad++; $display("FAIL same_cycle_write got=%h want=33333044", rsp_paddr); end
    @(negedge clk);
    total++;
    if (rsp_paddr !== 32'h4444_4044) begin bad++; $display("FAIL after_write got=%h want=44444044", rsp_paddr); end
    cur_asid = 8'h34;
    @(negedge clk);
    total++;
    if ({rsp_refill, miss_cnt} !== {1'b1, 16'd3}) begin bad++; $display("FAIL asid_change got rf=%b miss=%0d want rf=1 miss=3", rsp_refill, miss_cnt); end
    cur_asid = 8'h12;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({rsp_ex, rsp_paddr} !== {1'b0, 32'h4444_4044}) begin bad++; $display("FAIL asid_back got ex=%b pa=%h want ex=0 pa=44444044", rsp_ex, rsp_paddr); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_vaddr = 32'h8000_1000; req_wr = 1'b0;
    @(negedge clk);
    req_vaddr = 32'h8000_2000;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rsp_valid, req_ready, rsp_paddr, rsp_vaddr} !== {1'b1, 1'b0, 32'h0000_1000, 32'h8000_1000}) begin
        bad++; $display("FAIL stall_%0d got v=%b rdy=%b pa=%h want v=1 rdy=0 pa=00001000", i, rsp_valid, req_ready, rsp_paddr);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_paddr} !== {1'b1, 32'h0000_2000}) begin bad++; $display("FAIL b2b_1 got v=%b pa=%h want v=1 pa=00002000", rsp_valid, rsp_paddr); end
    req_vaddr = 32'h8000_3000;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_paddr} !== {1'b1, 32'h0000_3000}) begin bad++; $display("FAIL b2b_2 got v=%b pa=%h want v=1 pa=00003000", rsp_valid, rsp_paddr); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL drain got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_random;
    int k, e;
    for (int i = 0; i < 16; i++) tlb_write(i, rand_entry(i));
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      total++;
      if (obs_all !== exp_all) begin bad++; $display("FAIL rand_rsp cycle=%0d got=%h want=%h", n, obs_all, exp_all); end
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 7);
      req_wr    = $urandom_range(0, 1) == 1;
      k = $urandom_range(0, 9);
      e = $urandom_range(0, 15);
      cur_asid = ($urandom_range(0, 1) == 1) ? tlb[e].asid : 8'($urandom);
      if (k < 3)       req_vaddr = {2'b10, 30'($urandom)};
      else if (k == 3) req_vaddr = {19'h20000 + 19'($urandom_range(0, 255)), 13'($urandom)};
      else             req_vaddr = {tlb[e].vpn2, 13'($urandom)};
      w_en = ($urandom_range(0, 9) == 0);
      w_idx = 4'($urandom_range(0, 15));
      w_entry = rand_entry(int'(w_idx));
    end
    @(negedge clk);
    w_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    req_valid = 1'b1; req_vaddr = 32'h7FFF_0000; req_wr = 1'b0;
    repeat (65540) @(negedge clk);
    total++;
    if ({miss_cnt, rsp_refill} !== {16'hFFFF, 1'b1}) begin bad++; $display("FAIL miss_sat got miss=%h rf=%b want miss=ffff rf=1", miss_cnt, rsp_refill); end
    total++;
    if (obs_all !== exp_all) begin bad++; $display("FAIL sat_model got=%h want=%h", obs_all, exp_all); end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_pending;
    rsp_ready = 1'b0;
    send(32'h8000_0040, 1'b0, 8'h00);
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL pend_valid got=%b want=1", rsp_valid); end
    reset = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({rsp_valid, miss_cnt, req_ready, rsp_paddr} !== {1'b0, 16'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL reset_pending got v=%b miss=%h rdy=%b pa=%h want v=0 miss=0 rdy=1 pa=0", rsp_valid, miss_cnt, req_ready, rsp_paddr);
    end
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset got v=%b want 0", rsp_valid); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_vaddr = 32'd0; req_wr = 1'b0;
    cur_asid = 8'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) tlb[i] = mk(19'h7FFF0 + 19'(i), 8'h00, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    test_reset;
    test_unmapped;
    test_tlb_hit;
    test_exceptions;
    test_miss;
    test_asid_tlbwrite;
    test_back_to_back;
    test_random;
    test_saturation;
    test_reset_pending;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_xlate.md
ADDR_XLATE -- requirements
Module: addr_xlate

Interface
REQ-001 Parameter: TLBNUM, default 16, number of TLB entries; index width is clog2(TLBNUM).
REQ-002 One clock; reset is synchronous and active-high: clk input 1 is the clock, all state updates on its rising edge; reset input 1 is the synchronous active-high reset.
REQ-003 req_valid  in  1  translation request present.
REQ-004 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-005 req_vaddr  in  32  virtual address.
REQ-006 req_wr  in  1  1 = store access, 0 = load or fetch.
REQ-007 cur_asid  in  8  current ASID from CP0 EntryHi.
REQ-008 s_vpn2  out  19  TLB search VPN2; s_odd_page  out  1  TLB search odd-page select; s_asid  out  8  TLB search ASID.
REQ-009 s_found  in  1; s_index  in  clog2(TLBNUM); s_pfn  in  20; s_c  in  3; s_d  in  1; s_v  in  1; these are the TLB search results, combinational from the s_* outputs.
REQ-010 rsp_valid  out  1  response held in output register.
REQ-011 rsp_ready  in  1  consumer takes the response.
REQ-012 rsp_vaddr  out  32  echoed vaddr, used as BadVAddr.
REQ-013 rsp_paddr  out  32  physical address.
REQ-014 rsp_cached  out  1  cacheable access.
REQ-015 rsp_ex  out  1  exception; rsp_refill  out  1  TLB refill (miss); rsp_excode  out  5  exception code.
REQ-016 rsp_index  out  clog2(TLBNUM)  matching entry index.
REQ-017 miss_cnt  out  16  saturating count of mapped requests that missed.

Function
REQ-018 s_vpn2 shall be req_vaddr[31:13], s_odd_page shall be req_vaddr[12], and s_asid shall be cur_asid, all purely combinational.
REQ-019 req_ready shall equal !rsp_valid || rsp_ready, giving one output register with full throughput and no combinational path from req_valid to req_ready.
REQ-020 Accept = req_valid && req_ready; on Accept the translation result shall be registered, with rsp_valid=1 on the next cycle (latency 1).
REQ-021 If rsp_ready is high and there is no Accept, rsp_valid shall clear; while rsp_valid && !rsp_ready, all rsp_* outputs shall hold stable.
REQ-022 Unmapped segment (req_vaddr[31:30]==2'b10): rsp_paddr={3'b000,vaddr[28:0]}, rsp_cached=!vaddr[29], rsp_ex=0, rsp_index=0; the TLB result shall be ignored and miss_cnt shall not change.
REQ-023 Mapped segment, hit with s_v=1 and not (req_wr && !s_d): rsp_paddr={s_pfn,vaddr[11:0]}, rsp_cached=(s_c==3), rsp_ex=0, rsp_index=s_index.
REQ-024 Mapped segment, !s_found: rsp_ex=1, rsp_refill=1, rsp_excode=3 if req_wr else 2, and miss_cnt shall increment by 1, saturating at 16'hFFFF.
REQ-025 Mapped segment, s_found && !s_v: rsp_ex=1, rsp_refill=0, rsp_excode=3 if req_wr else 2.
REQ-026 Mapped segment, s_found && s_v && req_wr && !s_d: rsp_ex=1, rsp_refill=0, rsp_excode=1 (Mod).
REQ-027 Whenever rsp_ex=1: rsp_paddr=0, rsp_cached=0, rsp_index=s_index.
REQ-028 rsp_refill=0 and rsp_excode=0 whenever rsp_ex=0.
REQ-029 A TLB write in the same cycle as Accept shall not be visible; translation shall use pre-write contents.
REQ-030 A change of cur_asid shall affect only requests accepted after the change.

Reset
REQ-031 When reset is high at a clock edge: rsp_valid=0, rsp_vaddr=0, rsp_paddr=0, rsp_cached=0, rsp_ex=0, rsp_refill=0, rsp_excode=0, rsp_index=0, miss_cnt=0.
REQ-032 During reset, req_ready shall be 1 but no request shall be accepted.
REQ-033 A response pending when reset asserts shall be discarded.

Verification
REQ-034 Load vaddr=0x9FC0_1234 -> next cycle rsp_paddr=0x1FC0_1234, rsp_cached=1, rsp_ex=0; vaddr=0xBFC0_0000 -> rsp_paddr=0x1FC0_0000, rsp_cached=0.
REQ-035 TLB entry 5 with vpn2=0x00400, asid=0x12, pfn1=0x0ABCD, c1=3, v1=1; load vaddr=0x0080_1ABC with cur_asid=0x12 -> rsp_paddr=0x0ABC_DABC, rsp_cached=1, rsp_index=5.
REQ-036 Store to a mapped page whose d=0 -> rsp_ex=1, rsp_excode=1, rsp_refill=0; load to a page with v=0 -> rsp_excode=2, rsp_refill=0.
REQ-037 Load with no matching entry -> rsp_refill=1, rsp_excode=2, miss_cnt +1; with miss_cnt preset to 0xFFFF by 65535 misses, a further miss -> miss_cnt stays 0xFFFF.
REQ-038 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_* stable; raise rsp_ready -> back-to-back responses, one per cycle.
REQ-039 Assert reset while rsp_valid=1 -> next cycle rsp_valid=0 and miss_cnt=0.
